// File: rtl/keypad_pkg.sv
// Shared types, key codes and small helpers for the 4x3 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 3;
  localparam int unsigned CODE_W   = 8;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_REPORT,
    ST_RELEASE
  } state_t;

  typedef logic [1:0] row_idx_t;
  typedef logic [1:0] col_idx_t;

  localparam logic [CODE_W-1:0] KEY_0    = 8'h00;
  localparam logic [CODE_W-1:0] KEY_1    = 8'h01;
  localparam logic [CODE_W-1:0] KEY_2    = 8'h02;
  localparam logic [CODE_W-1:0] KEY_3    = 8'h03;
  localparam logic [CODE_W-1:0] KEY_4    = 8'h04;
  localparam logic [CODE_W-1:0] KEY_5    = 8'h05;
  localparam logic [CODE_W-1:0] KEY_6    = 8'h06;
  localparam logic [CODE_W-1:0] KEY_7    = 8'h07;
  localparam logic [CODE_W-1:0] KEY_8    = 8'h08;
  localparam logic [CODE_W-1:0] KEY_9    = 8'h09;
  localparam logic [CODE_W-1:0] KEY_STAR = 8'h0A;
  localparam logic [CODE_W-1:0] KEY_HASH = 8'h0B;

  // Map a (row, column) position on the pad to the code the CPU reads.
  function automatic logic [CODE_W-1:0] key_code(input row_idx_t row, input col_idx_t col);
    logic [CODE_W-1:0] code;
    code = KEY_0;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_0;
    endcase
    return code;
  endfunction

  // Active-low column pattern expected when only the given column is pulled down.
  function automatic logic [NUM_COLS-1:0] col_pattern(input col_idx_t col);
    logic [NUM_COLS-1:0] pat;
    pat = '1;
    case (col)
      2'd0:    pat = 3'b110;
      2'd1:    pat = 3'b101;
      2'd2:    pat = 3'b011;
      default: pat = '1;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad column lines.
module keypad_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] raw,
  output logic [NUM_COLS-1:0] sync
);

  logic [NUM_COLS-1:0] meta;

  // Reset to all-ones so an idle (pulled-up) pad reads as no key.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      sync <= '1;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row scan, press/release debounce, code latch and CPU interrupt pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 500,
  parameter int unsigned DEBOUNCE_CNT = 1_000_000,
  parameter int unsigned INT_WIDTH    = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              C,
  input  logic              A,
  input  logic              E,
  output logic              B,
  output logic              G,
  output logic              F,
  output logic              D,
  output logic [CODE_W-1:0] DATA,
  output logic              INTERRUPT
);

  localparam int unsigned DIV_W         = $clog2(SCAN_DIV);
  localparam int unsigned DB_W          = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned PW_W          = $clog2(INT_WIDTH);
  localparam int unsigned SETTLE_CYCLES = 3;

  logic [NUM_COLS-1:0] cols;

  keypad_sync u_sync (
    .clk   (CLK),
    .reset (RESET),
    .raw   ({E, A, C}),
    .sync  (cols)
  );

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  row_idx_t            row_q, row_d;
  col_idx_t            col_q, col_d;
  logic [DB_W-1:0]     db_q, db_d;
  logic [PW_W-1:0]     pw_q, pw_d;
  logic [CODE_W-1:0]   data_q, data_d;
  logic                int_q, int_d;
  logic [NUM_ROWS-1:0] rows_n_q, rows_n_d;

  logic     one_low_c;
  col_idx_t low_col_c;

  // Classify the synchronized columns: exactly one pulled low, and which one.
  always_comb begin
    one_low_c = 1'b1;
    low_col_c = 2'd0;
    case (cols)
      3'b110:  low_col_c = 2'd0;
      3'b101:  low_col_c = 2'd1;
      3'b011:  low_col_c = 2'd2;
      default: one_low_c = 1'b0;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    row_d   = row_q;
    col_d   = col_q;
    db_d    = db_q;
    pw_d    = pw_q;
    data_d  = data_q;
    int_d   = int_q;

    case (state_q)
      ST_SCAN: begin
        // Columns are only trusted once the newly driven row has settled through the synchronizer.
        if ((div_q >= DIV_W'(SETTLE_CYCLES)) && one_low_c) begin
          col_d   = low_col_c;
          db_d    = '0;
          state_d = ST_DEBOUNCE;
        end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          div_d = '0;
          row_d = row_q + 2'd1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (cols != col_pattern(col_q)) begin
          div_d   = '0;
          state_d = ST_SCAN;
        end else if (db_q == DB_W'(DEBOUNCE_CNT - 1)) begin
          data_d  = key_code(row_q, col_q);
          int_d   = 1'b1;
          pw_d    = '0;
          state_d = ST_REPORT;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end

      ST_REPORT: begin
        if (pw_q == PW_W'(INT_WIDTH - 1)) begin
          int_d   = 1'b0;
          db_d    = '0;
          state_d = ST_RELEASE;
        end else begin
          pw_d = pw_q + PW_W'(1);
        end
      end

      ST_RELEASE: begin
        // Row stays held, so any other key on it also keeps the count from completing.
        if (cols != '1) begin
          db_d = '0;
        end else if (db_q == DB_W'(DEBOUNCE_CNT - 1)) begin
          div_d   = '0;
          row_d   = row_q + 2'd1;
          state_d = ST_SCAN;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end

      default: state_d = ST_SCAN;
    endcase

    rows_n_d = ~(NUM_ROWS'(1) << row_d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_SCAN;
      div_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      db_q     <= '0;
      pw_q     <= '0;
      data_q   <= '0;
      int_q    <= 1'b0;
      rows_n_q <= 4'b1110;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      row_q    <= row_d;
      col_q    <= col_d;
      db_q     <= db_d;
      pw_q     <= pw_d;
      data_q   <= data_d;
      int_q    <= int_d;
      rows_n_q <= rows_n_d;
    end
  end

  assign B         = rows_n_q[0];
  assign G         = rows_n_q[1];
  assign F         = rows_n_q[2];
  assign D         = rows_n_q[3];
  assign DATA      = data_q;
  assign INTERRUPT = int_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a resistive-matrix keypad model on the row/column pins.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       c, a, e;
  logic       b, g, f, d;
  logic [7:0] data;
  logic       interrupt;
  logic [11:0] keys;  // index = row*3 + column

  int cyc;
  int checks;
  int passed;

  always #5 clk = ~clk;

  // A pressed key shorts its column to its row; a column reads low only while that row is driven low.
  assign c = ~((keys[0] & ~b) | (keys[3] & ~g) | (keys[6] & ~f) | (keys[9]  & ~d));
  assign a = ~((keys[1] & ~b) | (keys[4] & ~g) | (keys[7] & ~f) | (keys[10] & ~d));
  assign e = ~((keys[2] & ~b) | (keys[5] & ~g) | (keys[8] & ~f) | (keys[11] & ~d));

  keypad_scanner #(
    .SCAN_DIV     (8),
    .DEBOUNCE_CNT (16),
    .INT_WIDTH    (4)
  ) dut (
    .CLK       (clk),
    .RESET     (reset),
    .C         (c),
    .A         (a),
    .E         (e),
    .B         (b),
    .G         (g),
    .F         (f),
    .D         (d),
    .DATA      (data),
    .INTERRUPT (interrupt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic chk_out(input logic [7:0] exp_data, input logic exp_int);
    chk("data", data, exp_data);
    chk("interrupt", {7'b0, interrupt}, {7'b0, exp_int});
  endtask

  // Expected rows given as {D,F,G,B}, active-low.
  task automatic chk_rows(input logic [3:0] exp_rows);
    chk("rows", {4'b0, d, f, g, b}, {4'b0, exp_rows});
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until(input int stop, input logic [7:0] exp_data, input logic exp_int);
    while (cyc < stop) begin
      tick();
      chk_out(exp_data, exp_int);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic set_key(input int row, input int col, input logic down);
    keys[row*3 + col] = down;
  endtask

  initial begin
    logic [3:0] er;
    reset  = 1'b1;
    keys   = '0;
    cyc    = 0;
    checks = 0;
    passed = 0;

    // Idle scan after reset: one row low at a time, 8 cycles each.
    do_reset();
    chk_out(8'h00, 1'b0);
    chk_rows(4'b1110);
    for (int k = 1; k < 64; k++) begin
      tick();
      chk_out(8'h00, 1'b0);
      er = 4'b0001 << ((cyc / 8) % 4);
      chk_rows(~er);
    end

    // Key "5" held 200 cycles: detect at edge 12, pulse on cycles 28..31, none afterwards.
    do_reset();
    chk_out(8'h00, 1'b0);
    set_key(1, 1, 1'b1);
    run_until(27, 8'h00, 1'b0);
    run_until(31, 8'h05, 1'b1);
    run_until(100, 8'h05, 1'b0);
    chk_rows(4'b1101);
    run_until(200, 8'h05, 1'b0);
    set_key(1, 1, 1'b0);
    run_until(217, 8'h05, 1'b0);
    chk_rows(4'b1101);
    run_until(218, 8'h05, 1'b0);
    chk_rows(4'b1011);
    run_until(226, 8'h05, 1'b0);
    chk_rows(4'b0111);

    // Short "#" press on row 3: debounce aborts, row 3 resumes with a fresh divider.
    run_until(228, 8'h05, 1'b0);
    set_key(3, 2, 1'b1);
    run_until(236, 8'h05, 1'b0);
    chk_rows(4'b0111);
    run_until(238, 8'h05, 1'b0);
    set_key(3, 2, 1'b0);
    run_until(248, 8'h05, 1'b0);
    chk_rows(4'b0111);
    run_until(249, 8'h05, 1'b0);
    chk_rows(4'b1110);

    // "*" and "0" together are rejected; dropping "0" lets "*" through.
    run_until(250, 8'h05, 1'b0);
    set_key(3, 0, 1'b1);
    set_key(3, 1, 1'b1);
    run_until(284, 8'h05, 1'b0);
    set_key(3, 1, 1'b0);
    run_until(324, 8'h05, 1'b0);
    run_until(328, 8'h0A, 1'b1);
    run_until(340, 8'h0A, 1'b0);
    set_key(3, 0, 1'b0);
    run_until(357, 8'h0A, 1'b0);
    chk_rows(4'b0111);
    run_until(358, 8'h0A, 1'b0);
    chk_rows(4'b1110);

    // Reset in the middle of the "9" pulse, then re-detect with the key still held.
    run_until(360, 8'h0A, 1'b0);
    set_key(2, 2, 1'b1);
    run_until(393, 8'h0A, 1'b0);
    run_until(395, 8'h09, 1'b1);
    reset = 1'b1;
    tick();
    chk_out(8'h00, 1'b0);
    chk_rows(4'b1110);
    reset = 1'b0;
    run_until(431, 8'h00, 1'b0);
    run_until(435, 8'h09, 1'b1);
    run_until(450, 8'h09, 1'b0);
    set_key(2, 2, 1'b0);
    run_until(467, 8'h09, 1'b0);
    chk_rows(4'b1011);
    run_until(468, 8'h09, 1'b0);
    chk_rows(4'b0111);

    // "1", bouncy release, then "2": exactly two pulses.
    run_until(470, 8'h09, 1'b0);
    set_key(0, 0, 1'b1);
    run_until(495, 8'h09, 1'b0);
    run_until(499, 8'h01, 1'b1);
    run_until(510, 8'h01, 1'b0);
    set_key(0, 0, 1'b0);
    run_until(512, 8'h01, 1'b0);
    set_key(0, 0, 1'b1);
    run_until(514, 8'h01, 1'b0);
    set_key(0, 0, 1'b0);
    run_until(516, 8'h01, 1'b0);
    set_key(0, 0, 1'b1);
    run_until(518, 8'h01, 1'b0);
    set_key(0, 0, 1'b0);
    run_until(535, 8'h01, 1'b0);
    chk_rows(4'b1110);
    run_until(536, 8'h01, 1'b0);
    chk_rows(4'b1101);
    run_until(540, 8'h01, 1'b0);
    set_key(0, 1, 1'b1);
    run_until(579, 8'h01, 1'b0);
    run_until(583, 8'h02, 1'b1);
    run_until(600, 8'h02, 1'b0);
    set_key(0, 1, 1'b0);
    run_until(620, 8'h02, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have one clock `CLK`; reset `RESET` SHALL be synchronous and active-high.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
  - SCAN_DIV, 500, CLK cycles each row is driven during scanning (min 8).
  - DEBOUNCE_CNT, 1_000_000, consecutive stable cycles required for press and for release.
  - INT_WIDTH, 4, CLK cycles INTERRUPT is held high (>=2, so the 50 MHz CPU clock sees it).
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  - CLK  in  1  100 MHz system clock.
  - RESET  in  1  synchronous, active-high reset.
  - C, A, E  in  1 each  keypad columns 0/1/2; active-low; externally pulled up.
  - B, G, F, D  out  1 each  keypad rows 0/1/2/3; active-low drive.
  - DATA  out  8  code of last accepted key; feeds CPU input port 0x80.
  - INTERRUPT  out  1  key-accepted pulse to the CPU interrupt input.

Function
REQ-004 Column inputs SHALL pass through a 2-flop synchronizer before any use.
REQ-005 Exactly one row SHALL be driven low at any time; the other three SHALL be high.
REQ-006 Key codes SHALL be:
  - row0 = 1,2,3 -> 0x01..0x03
  - row1 = 4,5,6 -> 0x04..0x06
  - row2 = 7,8,9 -> 0x07..0x09
  - row3 = *,0,# -> 0x0A, 0x00, 0x0B
REQ-007 The FSM SHALL have the states SCAN, DEBOUNCE, REPORT and RELEASE.
REQ-008 In SCAN, a divider SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 the active row SHALL advance 0->1->2->3->0 and the divider SHALL return to 0.
REQ-009 In SCAN, synchronized columns SHALL be evaluated only when divider >= 3 (settling window).
  - Exactly one column low: latch row/column, clear the debounce counter, go to DEBOUNCE.
  - Zero or multiple columns low: stay in SCAN.
REQ-010 In DEBOUNCE, the row SHALL be held and the counter SHALL increment while the same single column stays low.
  - Any change: return to SCAN and resume the row scan from the held row with divider = 0.
  - Counter reaching DEBOUNCE_CNT-1: go to REPORT.
REQ-011 On entry to REPORT, DATA SHALL load the key code in the same cycle INTERRUPT rises.
  - INTERRUPT SHALL stay high for exactly INT_WIDTH cycles, then the FSM SHALL go to RELEASE.
REQ-012 In RELEASE, the row SHALL be held until all columns read high for DEBOUNCE_CNT consecutive cycles.
  - Any low column SHALL restart that count.
  - When the count completes, go to SCAN with divider = 0 and the row advanced by one.
REQ-013 A held key SHALL produce exactly one INTERRUPT pulse; auto-repeat SHALL not occur.
REQ-014 DATA SHALL change only on REPORT entry and SHALL otherwise hold its last value.
REQ-015 Latency: INTERRUPT SHALL rise exactly DEBOUNCE_CNT+1 cycles after the cycle in which SCAN detects the press.
REQ-016 A second key pressed while in REPORT or RELEASE SHALL be ignored until full release of all keys on the held row.
REQ-017 All counters SHALL be sized for their parameter maximum and SHALL never wrap inside a state.

Reset
REQ-018 When RESET is high at a CLK edge, the block SHALL go to the following values, with RESET taking priority over any state, including mid-DEBOUNCE and mid-REPORT:
  - state = SCAN, divider = 0, row 0 active (B=0; G, F, D = 1).
  - DATA = 0x00, INTERRUPT = 0.
  - debounce and pulse counters = 0, synchronizer flops = 1.

Structure
REQ-019 Package keypad_pkg SHALL hold the FSM state enum, the 12 key-code constants and the row/column index types.
REQ-020 Synchronization SHALL be one sub-module, keypad_sync: a 3-bit 2-flop synchronizer reset to all-ones.
REQ-021 The block SHALL be a drop-in for the existing keypad peripheral position between the keypad pins and the wrapper's input mux.

Verification
Directed scenarios use SCAN_DIV=8, DEBOUNCE_CNT=16, INT_WIDTH=4.
REQ-022 Reset then idle 64 cycles -> rows cycle B,G,F,D every 8 cycles; DATA=0x00; INTERRUPT never high.
REQ-023 Hold key "5" (row1, A low) for 200 cycles -> DATA=0x05; one 4-cycle INTERRUPT pulse, 17 cycles after detection; none during hold.
REQ-024 Press "#" (row3, E low) for 10 cycles, then release -> no INTERRUPT; DATA unchanged; scan resumes.
REQ-025 Press "*" and "0" together (row3, C and A low) -> no INTERRUPT; then release "0" only -> DATA=0x0A, one pulse.
REQ-026 Assert RESET during INTERRUPT high, with key "9" held -> next cycle INTERRUPT=0, DATA=0x00, B=0.
  - After deassert with "9" still held: DATA=0x09, one pulse.
REQ-027 Press "1", release with 8-cycle bounce glitches, press "2" -> exactly two pulses; DATA sequence 0x01 then 0x02.
